// File: rtl/vc_input_buffer_pkg.sv
// Shared types, defaults and helpers for the BFT router per-VC input stage.
package vc_input_buffer_pkg;

  localparam int DEFAULT_A_W           = 3;
  localparam int DEFAULT_D_W           = 8;
  localparam int DEFAULT_VC_W          = 2;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;

  // One storage slot is sacrificed so counts fit in $clog2(depth) bits.
  localparam int VC_FIFO_ENTRIES = DEFAULT_VC_FIFO_DEPTH - 1;

  typedef logic [DEFAULT_A_W+DEFAULT_D_W:0] flit_t;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/vc_input_buffer_fifo.sv
// Single-VC circular FIFO with a combinational head read and no bypass path.
module vc_fifo
  import vc_input_buffer_pkg::*;
#(
  parameter int W     = DEFAULT_A_W + DEFAULT_D_W + 1,
  parameter int DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         full
);

  localparam int ENTRIES = DEPTH - 1;
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W   = fifo_cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ENTRIES - 1);

  logic [W-1:0]     mem [ENTRIES];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(ENTRIES));
  assign head      = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_pop  = pop & not_empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Per-direction router input stage: per-VC FIFOs feeding t_switch, with credit return upstream.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int A_W           = DEFAULT_A_W,
  parameter int D_W           = DEFAULT_D_W,
  parameter int VC_W          = DEFAULT_VC_W,
  parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [A_W+D_W:0]              in_data,
  input  logic [VC_W-1:0]               in_v,
  output logic [VC_W-1:0]               in_credit_gnt,
  output logic [VC_W-1:0][A_W+D_W:0]    out_data,
  output logic [VC_W-1:0]               out_v,
  input  logic [VC_W-1:0]               out_bp,
  output logic                          err_overflow,
  output logic                          err_multihot
);

  logic [VC_W-1:0] push_sel;
  logic [VC_W-1:0] pop;
  logic [VC_W-1:0] full;
  logic            multihot;
  logic            overflow_hit;

  // Isolating the lowest set bit keeps a multi-hot input from writing more than one VC.
  assign push_sel     = in_v & (~in_v + VC_W'(1));
  assign multihot     = |(in_v & (in_v - VC_W'(1)));
  assign pop          = out_v & ~out_bp;
  assign overflow_hit = |(push_sel & full & ~pop);

  for (genvar v = 0; v < VC_W; v++) begin : gen_vc
    vc_fifo #(
      .W     (A_W + D_W + 1),
      .DEPTH (VC_FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_sel[v]),
      .push_data (in_data),
      .pop       (pop[v]),
      .head      (out_data[v]),
      .not_empty (out_v[v]),
      .full      (full[v])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_credit_gnt <= '0;
      err_overflow  <= 1'b0;
      err_multihot  <= 1'b0;
    end else begin
      in_credit_gnt <= pop;
      if (overflow_hit) err_overflow <= 1'b1;
      if (multihot)     err_multihot <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed and randomized bench for vc_input_buffer against a queue-based reference model.
module tb_vc_input_buffer;
  import vc_input_buffer_pkg::*;

  localparam int VC_W    = 2;
  localparam int DEPTH   = 4;
  localparam int ENTRIES = DEPTH - 1;
  localparam int FW      = DEFAULT_A_W + DEFAULT_D_W + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  flit_t                  in_data;
  logic [VC_W-1:0]        in_v;
  logic [VC_W-1:0]        in_credit_gnt;
  logic [VC_W-1:0][FW-1:0] out_data;
  logic [VC_W-1:0]        out_v;
  logic [VC_W-1:0]        out_bp;
  logic                   err_overflow;
  logic                   err_multihot;

  flit_t           q [VC_W][$];
  logic [VC_W-1:0] m_cred;
  logic            m_ovf;
  logic            m_mh;
  int              ups [VC_W];
  bit              inv_on;
  int              passes;
  int              total;

  always #5 clk = ~clk;

  vc_input_buffer #(
    .A_W           (DEFAULT_A_W),
    .D_W           (DEFAULT_D_W),
    .VC_W          (VC_W),
    .VC_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_v          (in_v),
    .in_credit_gnt (in_credit_gnt),
    .out_data      (out_data),
    .out_v         (out_v),
    .out_bp        (out_bp),
    .err_overflow  (err_overflow),
    .err_multihot  (err_multihot)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    for (int v = 0; v < VC_W; v++) begin
      check($sformatf("out_v%0d", v), 32'(out_v[v]), 32'(q[v].size() != 0));
      if (q[v].size() != 0)
        check($sformatf("out_data%0d", v), 32'(out_data[v]), 32'(q[v][0]));
      check($sformatf("credit%0d", v), 32'(in_credit_gnt[v]), 32'(m_cred[v]));
      if (inv_on) begin
        check($sformatf("credit_invariant%0d", v),
              32'(q[v].size() + int'(in_credit_gnt[v]) + ups[v]), 32'(ENTRIES));
        check($sformatf("ups_nonneg%0d", v), 32'(ups[v] >= 0), 32'd1);
      end
    end
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
    check("err_multihot", 32'(err_multihot), 32'(m_mh));
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUT.
  task automatic applyStimulus(input logic [VC_W-1:0] v, input flit_t d, input logic [VC_W-1:0] bp);
    logic [VC_W-1:0] pop;
    int sel;
    in_v = v; in_data = d; out_bp = bp;
    @(posedge clk);
    for (int i = 0; i < VC_W; i++) ups[i] += int'(m_cred[i]);
    for (int i = 0; i < VC_W; i++) pop[i] = (q[i].size() != 0) && !bp[i];
    m_cred = pop;
    for (int i = 0; i < VC_W; i++) if (pop[i]) void'(q[i].pop_front());
    sel = -1;
    for (int i = VC_W - 1; i >= 0; i--) if (v[i]) sel = i;
    if ($countones(v) > 1) m_mh = 1'b1;
    if (sel >= 0) begin
      ups[sel] -= 1;
      if (q[sel].size() < ENTRIES) q[sel].push_back(d);
      else m_ovf = 1'b1;
    end
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_v = '0; in_data = '0; out_bp = '0;
    #1;
    check("rst_out_v", 32'(out_v), 32'd0);
    check("rst_credit", 32'(in_credit_gnt), 32'd0);
    check("rst_err_ovf", 32'(err_overflow), 32'd0);
    check("rst_err_mh", 32'(err_multihot), 32'd0);
    for (int i = 0; i < VC_W; i++) begin
      q[i].delete();
      ups[i] = ENTRIES;
    end
    m_cred = '0; m_ovf = 1'b0; m_mh = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [VC_W-1:0] rv;
    int vc;
    passes = 0; total = 0; inv_on = 0;
    doReset();
    checkOutput();

    $display("[TB] fill VC0 under backpressure, then drain");
    applyStimulus(2'b01, flit_t'(12'hA0A), 2'b11);
    check("t2_head_a", 32'(out_data[0]), 32'h0A0A);
    check("t2_v_after_a", 32'(out_v[0]), 32'd1);
    applyStimulus(2'b01, flit_t'(12'hB0B), 2'b11);
    applyStimulus(2'b01, flit_t'(12'hC0C), 2'b11);
    check("t2_head_still_a", 32'(out_data[0]), 32'h0A0A);
    applyStimulus(2'b00, '0, 2'b10);
    check("t2_credit_pop1", 32'(in_credit_gnt[0]), 32'd1);
    check("t2_head_b", 32'(out_data[0]), 32'h0B0B);
    applyStimulus(2'b00, '0, 2'b10);
    check("t2_head_c", 32'(out_data[0]), 32'h0C0C);
    applyStimulus(2'b00, '0, 2'b10);
    check("t2_credit_pop3", 32'(in_credit_gnt[0]), 32'd1);
    check("t2_empty", 32'(out_v[0]), 32'd0);
    applyStimulus(2'b00, '0, 2'b10);
    check("t2_credit_done", 32'(in_credit_gnt[0]), 32'd0);

    $display("[TB] push and pop together on a full VC1");
    for (int i = 0; i < ENTRIES; i++) applyStimulus(2'b10, flit_t'(12'h110 + i), 2'b11);
    applyStimulus(2'b10, flit_t'(12'hD0D), 2'b01);
    check("t3_no_overflow", 32'(err_overflow), 32'd0);
    check("t3_still_full_head", 32'(out_data[1]), 32'h0111);
    for (int i = 0; i < ENTRIES + 1; i++) applyStimulus(2'b00, '0, 2'b01);

    $display("[TB] overflow on full VC0");
    for (int i = 0; i < ENTRIES; i++) applyStimulus(2'b01, flit_t'(12'h200 + i), 2'b11);
    applyStimulus(2'b01, flit_t'(12'hE0E), 2'b11);
    check("t4_overflow_set", 32'(err_overflow), 32'd1);
    check("t4_no_credit", 32'(in_credit_gnt), 32'd0);
    applyStimulus(2'b00, '0, 2'b11);
    check("t4_overflow_sticky", 32'(err_overflow), 32'd1);
    for (int i = 0; i < ENTRIES + 1; i++) applyStimulus(2'b00, '0, 2'b10);

    $display("[TB] multi-hot input");
    applyStimulus(2'b11, flit_t'(12'hF0F), 2'b11);
    check("t5_vc0_gets_f", 32'(out_data[0]), 32'h0F0F);
    check("t5_vc1_empty", 32'(out_v[1]), 32'd0);
    check("t5_multihot", 32'(err_multihot), 32'd1);
    applyStimulus(2'b10, flit_t'(12'h333), 2'b11);

    $display("[TB] reset mid-burst");
    #3;
    doReset();
    checkOutput();

    $display("[TB] randomized traffic with upstream credit counter");
    inv_on = 1;
    for (int c = 0; c < 400; c++) begin
      rv = '0;
      if ($urandom_range(0, 3) != 0) begin
        vc = int'($urandom_range(0, VC_W - 1));
        if (ups[vc] > 0) rv[vc] = 1'b1;
      end
      applyStimulus(rv, flit_t'($urandom), VC_W'($urandom));
    end
    for (int c = 0; c < 2 * ENTRIES; c++) applyStimulus('0, '0, '0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
